// File: rtl/fpadd_pkg.sv
// fpadd_pkg -- shared definitions for the FP adder operand path.
//   FP_W          : operand / result width (IEEE-754 single)
//   seq_state_t   : operand sequencer state encoding (IDLE = 0)
//   state_busy()  : true for the states in which a run is in progress
package fpadd_pkg;

    localparam int FP_W = 32;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_HOLD  = 3'd5,
        S_DONE  = 3'd6
    } seq_state_t;

    function automatic logic state_busy(seq_state_t s);
        return (s == S_FETCH) || (s == S_LOAD) || (s == S_ISSUE) ||
               (s == S_WAIT)  || (s == S_HOLD);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer -- counts the display hold interval.
//   clk, rst : clock, asynchronous active-low reset
//   clear    : restart the count from zero (has priority over enable)
//   enable   : advance the count this cycle
//   expire   : high on the last enabled cycle of a HOLD_CYCLES interval
// With HOLD_CYCLES = 1, expire is high on the first enabled cycle.
module hold_timer #(
    parameter int HOLD_CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt;

    assign expire = enable && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            // wrap on expiry so a re-entry without a clear still starts at 0
            cnt <= expire ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fp_operand_sequencer.sv
// fp_operand_sequencer -- walks an operand ROM, feeds each pair to an FP
// adder over a valid/ready handshake and holds each result for display.
//   clk, rst          : clock, asynchronous active-low reset
//   start             : level; begins a run when seen in IDLE or DONE
//   mem_addr          : ROM address (data returns one cycle later)
//   mem_a, mem_b      : ROM data
//   op_a, op_b        : adder operands, stable while op_valid is high
//   op_valid/op_ready : operand handshake
//   res_valid, res    : adder result strobe, only honoured while waiting
//   disp_result       : last latched result (LED / 7-segment stage)
//   disp_index        : pair index of disp_result
//   busy, done        : status, never both high
// Build option: define FPSEQ_LOOP_EN to wrap from the last pair back to
// pair 0 forever instead of stopping in DONE.
module fp_operand_sequencer
    import fpadd_pkg::*;
#(
    parameter int NUM         = 10,
    parameter int HOLD_CYCLES = 50000000,
    localparam int AW         = (NUM > 1) ? $clog2(NUM) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [AW-1:0]   mem_addr,
    input  logic [FP_W-1:0] mem_a,
    input  logic [FP_W-1:0] mem_b,
    output logic [FP_W-1:0] op_a,
    output logic [FP_W-1:0] op_b,
    output logic            op_valid,
    input  logic            op_ready,
    input  logic            res_valid,
    input  logic [FP_W-1:0] res,
    output logic [FP_W-1:0] disp_result,
    output logic [AW-1:0]   disp_index,
    output logic            busy,
    output logic            done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM - 1);

    seq_state_t    state;
    logic [AW-1:0] idx;
    logic          hold_clear;
    logic          hold_en;
    logic          hold_expire;

    // The ROM is addressed straight from the registered pair index.
    assign mem_addr = idx;

    // Counter restarts on the same edge the result is latched.
    assign hold_clear = (state == S_WAIT) && res_valid;
    assign hold_en    = (state == S_HOLD);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clear  (hold_clear),
        .enable (hold_en),
        .expire (hold_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            idx         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_valid    <= 1'b0;
            disp_result <= '0;
            disp_index  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_FETCH;
                        idx   <= '0;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                // address is out; ROM data lands during LOAD
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    op_a     <= mem_a;
                    op_b     <= mem_b;
                    op_valid <= 1'b1;
                    state    <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (op_valid && op_ready) begin
                        op_valid <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        disp_result <= res;
                        disp_index  <= idx;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hold_expire) begin
                        if (idx < LAST_IDX) begin
                            idx   <= idx + AW'(1);
                            state <= S_FETCH;
                        end else begin
`ifdef FPSEQ_LOOP_EN
                            idx   <= '0;
                            state <= S_FETCH;
`else
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
`endif
                        end
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    op_valid <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

endmodule
